// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the reg_bank register file.
// Default geometry and the address-width helper used by reg_bank and reg_bank_rdport.
package reg_bank_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 10;

  // Smallest address width that can index 'depth' registers (at least 1 bit).
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port of reg_bank: range check, zero fill, output register.
// Same-cycle write-to-read bypass is included when REG_BANK_BYPASS_EN is defined.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = addr_width(DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
`ifdef REG_BANK_BYPASS_EN
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
`endif
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] rdata,
  output logic             oor
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             in_range;
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_comb begin
    in_range = ({1'b0, raddr} < DEPTH_W);
    oor      = re & ~in_range;
    rdata_d  = rdata_q;
    if (re) begin
      rdata_d = '0;
      if (in_range) begin
        rdata_d = mem[raddr];
`ifdef REG_BANK_BYPASS_EN
        // raddr is in range here, so a match also implies waddr is in range.
        if (we && (waddr == raddr)) rdata_d = wdata;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: one write port, two registered read ports, sticky range-error flag.
// Define REG_BANK_BYPASS_EN to make same-cycle reads of waddr return the new wdata.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = addr_width(DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid,
  input  logic             err_clr,
  output logic             err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rvalid_d, rvalid_q;
  logic             err_d, err_q;
  logic             wr_in_range;
  logic             oor_a, oor_b;

  always_comb begin
    wr_in_range = ({1'b0, waddr} < DEPTH_W);
    mem_d       = mem_q;
    if (we && wr_in_range) mem_d[waddr] = wdata;
    rvalid_d = re;
    // A set event on this edge wins over a simultaneous clear.
    err_d = (we & ~wr_in_range) | oor_a | oor_b | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (re),
    .raddr (raddr_a),
`ifdef REG_BANK_BYPASS_EN
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
`endif
    .mem   (mem_q),
    .rdata (rdata_a),
    .oor   (oor_a)
  );

  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (re),
    .raddr (raddr_b),
`ifdef REG_BANK_BYPASS_EN
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
`endif
    .mem   (mem_q),
    .rdata (rdata_b),
    .oor   (oor_b)
  );

  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank with a reference model and a read-data scoreboard.
module tb_reg_bank;

  localparam int WIDTH = 16;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             rvalid;
  logic             err_clr;
  logic             err;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rvalid  (rvalid),
    .err_clr (err_clr),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } rd_t;

  rd_t              sb[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic             model_err;
  logic [WIDTH-1:0] last_a, last_b;
  int               pass_cnt;
  int               total_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int ra, input logic w,
                                                  input int wa, input logic [WIDTH-1:0] wd);
    if (ra >= DEPTH) return '0;
`ifdef REG_BANK_BYPASS_EN
    if (w && wa == ra) return wd;
`endif
    return model_mem[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_err = 1'b0;
    last_a    = '0;
    last_b    = '0;
    sb.delete();
  endtask

  // Drives one cycle of stimulus, updates the model, and checks the DUT after the edge.
  task automatic step(input string tag, input logic w, input int wa, input logic [WIDTH-1:0] wd,
                      input logic r, input int ra, input int rb, input logic clr);
    rd_t e;
    logic set;
    we = w; waddr = AW'(wa); wdata = wd;
    re = r; raddr_a = AW'(ra); raddr_b = AW'(rb); err_clr = clr;
    set = (w && wa >= DEPTH) || (r && (ra >= DEPTH || rb >= DEPTH));
    if (r) begin
      e.a = model_read(ra, w, wa, wd);
      e.b = model_read(rb, w, wa, wd);
      sb.push_back(e);
    end
    if (w && wa < DEPTH) model_mem[wa] = wd;
    model_err = set | (model_err & ~clr);
    @(posedge clk);
    #1;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(r));
    if (r) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, ".rdata_a"}, 32'(rdata_a), 32'(e.a));
        chk({tag, ".rdata_b"}, 32'(rdata_b), 32'(e.b));
        last_a = e.a;
        last_b = e.b;
      end
    end else begin
      chk({tag, ".hold_a"}, 32'(rdata_a), 32'(last_a));
      chk({tag, ".hold_b"}, 32'(rdata_b), 32'(last_b));
    end
    chk({tag, ".err"}, 32'(err), 32'(model_err));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re = 1'b0; raddr_a = '0; raddr_b = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdata_a", 32'(rdata_a), 32'd0);
    chk("reset.rdata_b", 32'(rdata_b), 32'd0);
    chk("reset.rvalid",  32'(rvalid),  32'd0);
    chk("reset.err",     32'(err),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then dual read of the same address.
    step("wr3",   1'b1, 3, 16'h1234, 1'b0, 0, 0, 1'b0);
    step("rd3_3", 1'b0, 0, 16'h0000, 1'b1, 3, 3, 1'b0);

    // Same-cycle write and read of address 9; the write must still land.
    step("wr9_rd9", 1'b1, 9, 16'hBEEF, 1'b1, 9, 3, 1'b0);
    step("rd9",     1'b0, 0, 16'h0000, 1'b1, 9, 9, 1'b0);

    // Out-of-range read on port A only; sticky err and clear.
    step("wr0",      1'b1, 0, 16'h00A5, 1'b0, 0, 0, 1'b0);
    step("rd12_0",   1'b0, 0, 16'h0000, 1'b1, 12, 0, 1'b0);
    step("err_hold", 1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b0);
    step("set_clr",  1'b0, 0, 16'h0000, 1'b1, 0, 15, 1'b1);
    step("err_clr",  1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b1);
    step("err_idle", 1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b0);

    // Out-of-range write must not disturb storage.
    step("wr15", 1'b1, 15, 16'hFFFF, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step("rb_wr15", 1'b0, 0, 16'h0000, 1'b1, i, DEPTH - 1 - i, 1'b0);
    step("clr2", 1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b1);

    // Back-to-back reads, then hold.
    for (int i = 0; i < 4; i++)
      step("b2b", 1'b1, i + 4, 16'(16'h0100 + i), 1'b1, i, 3 - i, 1'b0);
    step("hold1", 1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b0);
    step("hold2", 1'b0, 0, 16'h0000, 1'b0, 5, 6, 1'b0);

    // Mixed random traffic, addresses cover the out-of-range region.
    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0));

    // Reset asserted mid-read between edges with a write pending across an edge.
    step("pre_rst", 1'b1, 2, 16'h5A5A, 1'b1, 2, 4, 1'b0);
    we = 1'b1; waddr = 4'd7; wdata = 16'hC3C3; re = 1'b1; raddr_a = 4'd2; raddr_b = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.rdata_a", 32'(rdata_a), 32'd0);
    chk("rst_mid.rdata_b", 32'(rdata_b), 32'd0);
    chk("rst_mid.rvalid",  32'(rvalid),  32'd0);
    chk("rst_mid.err",     32'(err),     32'd0);
    @(negedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;
    step("post_rst", 1'b0, 0, 16'h0000, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step("rb_rst", 1'b0, 0, 16'h0000, 1'b1, i, i, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
